// File: rtl/icmp_reply_tx.sv
// ICMP echo-reply builder: swaps addresses, clears the type byte, fixes the checksum, and streams the frame.
// Build option ICMP_CSUM_RECALC_EN replaces the incremental checksum patch with a full recomputation.
module icmp_reply_tx #(
    parameter int FRM_SZ     = 74,
    parameter int IFG_CYCLES = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [47:0]         hw_addr_i,
    input  logic [31:0]         ip_addr_i,
    input  logic [FRM_SZ*8-1:0] icmp_pkt_i,
    input  logic                icmp_pkt_valid_i,
    output logic [7:0]          mac_data_o,
    output logic                mac_valid_o,
    input  logic                mac_ready_i,
    output logic                busy_o,
    output logic [7:0]          drop_cnt_o
);
    localparam int IDX_W = $clog2(FRM_SZ);
    localparam int GAP_W = $clog2(IFG_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRM_SZ - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_CYCLES);

    localparam int DST_MAC_MSB = FRM_SZ*8 - 1;
    localparam int SRC_MAC_MSB = (FRM_SZ - 6)*8 - 1;
    localparam int SRC_IP_MSB  = (FRM_SZ - 26)*8 - 1;
    localparam int DST_IP_MSB  = (FRM_SZ - 30)*8 - 1;
    localparam int TYPE_MSB    = (FRM_SZ - 34)*8 - 1;
    localparam int CSUM_MSB    = (FRM_SZ - 36)*8 - 1;

`ifdef ICMP_CSUM_RECALC_EN
    typedef enum logic [1:0] {ST_IDLE, ST_CSUM, ST_SEND, ST_GAP} state_t;
    localparam logic [IDX_W-1:0] CSUM_DONE = IDX_W'((FRM_SZ - 34 + 1) / 2);
`else
    typedef enum logic [1:0] {ST_IDLE, ST_BUILD, ST_SEND, ST_GAP} state_t;
`endif

    state_t              state_q, state_d;
    logic [FRM_SZ*8-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [7:0]          data_q, data_d;
    logic                valid_q, valid_d;
    logic [7:0]          drop_q, drop_d;

    function automatic logic [7:0] frame_byte(input logic [FRM_SZ*8-1:0] frm, input int idx);
        frame_byte = 8'h00;
        if (idx >= 0 && idx < FRM_SZ) frame_byte = frm[(FRM_SZ-1-idx)*8 +: 8];
    endfunction

`ifdef ICMP_CSUM_RECALC_EN
    logic [31:0] csum_q, csum_d;
    logic [15:0] csum_word;
    logic [16:0] fold1;
    logic [15:0] fold2;
    int          hi_idx;

    // Type (34) and checksum (36-37) read as zero; an index past the frame end pads with zero.
    always_comb begin
        hi_idx    = 34 + 2 * int'(idx_q);
        csum_word = {(hi_idx == 34 || hi_idx == 36) ? 8'h00 : frame_byte(buf_q, hi_idx),
                     (hi_idx + 1 == 37) ? 8'h00 : frame_byte(buf_q, hi_idx + 1)};
        fold1     = {1'b0, csum_q[15:0]} + {1'b0, csum_q[31:16]};
        fold2     = fold1[15:0] + {15'd0, fold1[16]};
    end
`else
    logic [16:0] csum_sum;
    logic [15:0] csum_new;

    // Type 8 -> 0 lowers the covered sum by 0x0800, so the stored complement rises by the same.
    always_comb begin
        csum_sum = {1'b0, buf_q[CSUM_MSB -: 16]} + 17'h0_0800;
        csum_new = csum_sum[15:0] + {15'd0, csum_sum[16]};
    end
`endif

    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        data_d  = data_q;
        valid_d = valid_q;
        drop_d  = drop_q;
`ifdef ICMP_CSUM_RECALC_EN
        csum_d  = csum_q;
`endif
        if (icmp_pkt_valid_i && (state_q != ST_IDLE) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

        case (state_q)
            ST_IDLE: begin
                if (icmp_pkt_valid_i) begin
                    buf_d = icmp_pkt_i;
                    idx_d = '0;
`ifdef ICMP_CSUM_RECALC_EN
                    csum_d  = '0;
                    state_d = ST_CSUM;
`else
                    state_d = ST_BUILD;
`endif
                end
            end
`ifdef ICMP_CSUM_RECALC_EN
            ST_CSUM: begin
                if (idx_q == '0) begin
                    buf_d[DST_MAC_MSB -: 48] = buf_q[SRC_MAC_MSB -: 48];
                    buf_d[SRC_MAC_MSB -: 48] = hw_addr_i;
                    buf_d[DST_IP_MSB -: 32]  = buf_q[SRC_IP_MSB -: 32];
                    buf_d[SRC_IP_MSB -: 32]  = ip_addr_i;
                end
                if (idx_q == CSUM_DONE) begin
                    buf_d[TYPE_MSB -: 8]  = 8'h00;
                    buf_d[CSUM_MSB -: 16] = ~fold2;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end else begin
                    csum_d = csum_q + {16'd0, csum_word};
                    idx_d  = idx_q + IDX_W'(1);
                end
            end
`else
            ST_BUILD: begin
                buf_d[DST_MAC_MSB -: 48] = buf_q[SRC_MAC_MSB -: 48];
                buf_d[SRC_MAC_MSB -: 48] = hw_addr_i;
                buf_d[DST_IP_MSB -: 32]  = buf_q[SRC_IP_MSB -: 32];
                buf_d[SRC_IP_MSB -: 32]  = ip_addr_i;
                buf_d[TYPE_MSB -: 8]     = 8'h00;
                buf_d[CSUM_MSB -: 16]    = csum_new;
                idx_d   = '0;
                state_d = ST_SEND;
            end
`endif
            ST_SEND: begin
                // The first SEND cycle only loads byte 0 into the output register.
                if (!valid_q) begin
                    data_d  = frame_byte(buf_q, int'(idx_q));
                    valid_d = 1'b1;
                end else if (mac_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        data_d = frame_byte(buf_q, int'(idx_q) + 1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_q <= GAP_W'(1)) state_d = ST_IDLE;
                else                    gap_d   = gap_q - GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the frame buffer is reset too, so a request aborted by reset leaves no stale bytes behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= '0;
`ifdef ICMP_CSUM_RECALC_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
`ifdef ICMP_CSUM_RECALC_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign mac_data_o  = data_q;
    assign mac_valid_o = valid_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign drop_cnt_o  = drop_q;
endmodule

// File: tb/tb_icmp_reply_tx.sv
// Randomized bench for icmp_reply_tx: byte-array reply model, latency, backpressure, drops, reset.
module tb_icmp_reply_tx;
    localparam int FRM_SZ     = 74;
    localparam int IFG_CYCLES = 12;
`ifdef ICMP_CSUM_RECALC_EN
    localparam int EXTRA = (FRM_SZ - 34 + 1) / 2;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT_FIRST = 3 + EXTRA;
    localparam int LAT_IDLE  = FRM_SZ + IFG_CYCLES + 3 + EXTRA;

    typedef logic [7:0] frame_b_t [FRM_SZ];

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [47:0]         hw_addr_i = 48'h02_00_00_00_00_AA;
    logic [31:0]         ip_addr_i = 32'h0A_00_00_02;
    logic [FRM_SZ*8-1:0] icmp_pkt_i = '0;
    logic                icmp_pkt_valid_i = 1'b0;
    logic [7:0]          mac_data_o;
    logic                mac_valid_o;
    logic                mac_ready_i = 1'b1;
    logic                busy_o;
    logic [7:0]          drop_cnt_o;

    int ready_mode = 0;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] rx_q[$];
    int         st_q[$];
    int         hold_err = 0;
    int         vgap_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    icmp_reply_tx #(.FRM_SZ(FRM_SZ), .IFG_CYCLES(IFG_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .hw_addr_i(hw_addr_i), .ip_addr_i(ip_addr_i),
        .icmp_pkt_i(icmp_pkt_i), .icmp_pkt_valid_i(icmp_pkt_valid_i),
        .mac_data_o(mac_data_o), .mac_valid_o(mac_valid_o), .mac_ready_i(mac_ready_i),
        .busy_o(busy_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        mac_ready_i = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? ((cyc % 3) != 0) : 1'b0;
    end

    // Collects accepted bytes and watches for valid dropping mid-frame or data changing while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_q.delete();
            st_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && mac_valid_o && (mac_data_o != prev_data)) hold_err++;
            if (!mac_valid_o && (rx_q.size() % FRM_SZ) != 0) vgap_err++;
            if (mac_valid_o && mac_ready_i) begin
                rx_q.push_back(mac_data_o);
                st_q.push_back(cyc);
            end
            prev_stall = mac_valid_o && !mac_ready_i;
            prev_data  = mac_data_o;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [FRM_SZ*8-1:0] pack(input frame_b_t f);
        logic [FRM_SZ*8-1:0] r;
        for (int i = 0; i < FRM_SZ; i++) r[(FRM_SZ-1-i)*8 +: 8] = f[i];
        return r;
    endfunction

    function automatic logic [7:0] rx_at(input int idx);
        if (idx < rx_q.size()) return rx_q[idx];
        return 8'hxx;
    endfunction

    task automatic rand_frame(output frame_b_t f);
        for (int i = 0; i < FRM_SZ; i++) f[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic make_req(output frame_b_t f, input logic [47:0] smac, input logic [31:0] sip,
                            input logic [15:0] csum);
        rand_frame(f);
        for (int i = 0; i < 6; i++) begin
            f[i]     = hw_addr_i[47-8*i -: 8];
            f[6 + i] = smac[47-8*i -: 8];
        end
        for (int i = 0; i < 4; i++) begin
            f[26 + i] = sip[31-8*i -: 8];
            f[30 + i] = ip_addr_i[31-8*i -: 8];
        end
        f[34] = 8'h08;
        f[35] = 8'h00;
        f[36] = csum[15:8];
        f[37] = csum[7:0];
    endtask

    // Reference reply: field-level rewrite of the request's byte array.
    task automatic build_reply(input frame_b_t req, output frame_b_t rep);
        int s;
        rep = req;
        for (int i = 0; i < 6; i++) begin
            rep[i]     = req[6 + i];
            rep[6 + i] = hw_addr_i[47-8*i -: 8];
        end
        for (int i = 0; i < 4; i++) begin
            rep[30 + i] = req[26 + i];
            rep[26 + i] = ip_addr_i[31-8*i -: 8];
        end
        rep[34] = 8'h00;
`ifdef ICMP_CSUM_RECALC_EN
        rep[36] = 8'h00;
        rep[37] = 8'h00;
        s = 0;
        for (int j = 34; j < FRM_SZ; j += 2)
            s += int'(rep[j]) * 256 + ((j + 1 < FRM_SZ) ? int'(rep[j + 1]) : 0);
        while (s > 'hFFFF) s = (s & 'hFFFF) + (s >>> 16);
        s = ~s & 'hFFFF;
`else
        s = int'({req[36], req[37]}) + 'h0800;
        if (s > 'hFFFF) s = s - 'hFFFF;
`endif
        rep[36] = s[15:8];
        rep[37] = s[7:0];
    endtask

    task automatic strobe(input frame_b_t f);
        icmp_pkt_i       = pack(f);
        icmp_pkt_valid_i = 1'b1;
        step();
        icmp_pkt_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int t);
        int k = 0;
        while (busy_o && k < 3000) begin
            step();
            k++;
        end
        t = cyc;
        check({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    task automatic compare_frame(input string tag, input int base, input frame_b_t req);
        frame_b_t exp;
        build_reply(req, exp);
        check({tag, "_len"}, 32'(rx_q.size() - base), 32'(FRM_SZ));
        for (int i = 0; i < FRM_SZ; i++)
            check($sformatf("%s_b%0d", tag, i), 32'(rx_at(base + i)), 32'(exp[i]));
    endtask

    // Single request with ready held high; checks timing and content.
    task automatic run_frame(input string tag, input frame_b_t req, output int base);
        int c0, t;
        base = rx_q.size();
        c0   = cyc;
        strobe(req);
        check({tag, "_busy"}, 32'(busy_o), 32'd1);
        wait_idle(tag, t);
        check({tag, "_idle_lat"}, 32'(t - c0), 32'(LAT_IDLE));
        check({tag, "_first_lat"}, (st_q.size() > base) ? 32'(st_q[base] - c0) : 32'hFFFF_FFFF,
              32'(LAT_FIRST));
        compare_frame(tag, base, req);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        repeat (3) step();
        check({tag, "_valid"}, 32'(mac_valid_o), 32'd0);
        check({tag, "_data"}, 32'(mac_data_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_drop"}, 32'(drop_cnt_o), 32'd0);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        frame_b_t f, g;
        int base, t, k;

        do_reset("reset");

        make_req(f, 48'h02_00_00_00_00_01, 32'h0A_00_00_01, 16'h4D5A);
        run_frame("basic", f, base);
        check("basic_dmac5", 32'(rx_at(base + 5)), 32'h01);
        check("basic_smac5", 32'(rx_at(base + 11)), 32'hAA);
        check("basic_sip", {rx_at(base + 26), rx_at(base + 27), rx_at(base + 28), rx_at(base + 29)},
              32'h0A00_0002);
        check("basic_dip", {rx_at(base + 30), rx_at(base + 31), rx_at(base + 32), rx_at(base + 33)},
              32'h0A00_0001);
        check("basic_type", 32'(rx_at(base + 34)), 32'h00);
`ifndef ICMP_CSUM_RECALC_EN
        check("basic_csum", 32'({rx_at(base + 36), rx_at(base + 37)}), 32'h555A);
`endif

        make_req(f, 48'h02_11_22_33_44_55, 32'hC0A8_0105, 16'hF800);
        run_frame("wrap0", f, base);
`ifndef ICMP_CSUM_RECALC_EN
        check("wrap0_csum", 32'({rx_at(base + 36), rx_at(base + 37)}), 32'h0001);
`endif
        make_req(f, 48'h02_66_77_88_99_00, 32'hC0A8_0106, 16'hF7FF);
        run_frame("wrap1", f, base);
`ifndef ICMP_CSUM_RECALC_EN
        check("wrap1_csum", 32'({rx_at(base + 36), rx_at(base + 37)}), 32'hFFFF);
`endif

        make_req(f, 48'h02_00_00_00_00_07, 32'h0A_00_00_07, 16'h0000);
        run_frame("badcsum", f, base);

        ready_mode = 1;
        step();
        make_req(f, {16'h0200, $urandom()}, $urandom(), 16'($urandom()));
        base = rx_q.size();
        strobe(f);
        wait_idle("bp", t);
        compare_frame("bp", base, f);
        check("bp_vgap", 32'(vgap_err), 32'd0);
        check("bp_hold", 32'(hold_err), 32'd0);
        ready_mode = 0;
        step();

        make_req(f, {16'h0200, $urandom()}, $urandom(), 16'($urandom()));
        base = rx_q.size();
        strobe(f);
        repeat (9) step();
        rand_frame(g);
        strobe(g);
        k = 0;
        while (rx_q.size() < base + FRM_SZ && k < 500) begin
            step();
            k++;
        end
        repeat (3) step();
        check("drop_in_gap_busy", 32'(busy_o), 32'd1);
        rand_frame(g);
        strobe(g);
        wait_idle("drop", t);
        check("drop_cnt", 32'(drop_cnt_o), 32'd2);
        repeat (20) step();
        compare_frame("drop_one", base, f);
        make_req(f, {16'h0200, $urandom()}, $urandom(), 16'($urandom()));
        run_frame("after_drop", f, base);

        do_reset("reset2");
        ready_mode = 2;
        repeat (2) step();
        make_req(f, {16'h0200, $urandom()}, $urandom(), 16'($urandom()));
        base = rx_q.size();
        icmp_pkt_i       = pack(f);
        icmp_pkt_valid_i = 1'b1;
        step();
        for (int n = 1; n <= 300; n++) begin
            rand_frame(g);
            icmp_pkt_i = pack(g);
            step();
            if (n == 100 || n == 255 || n == 300)
                check($sformatf("sat_%0d", n), 32'(drop_cnt_o), 32'((n < 255) ? n : 255));
        end
        icmp_pkt_valid_i = 1'b0;
        check("sat_busy", 32'(busy_o), 32'd1);
        ready_mode = 0;
        wait_idle("sat", t);
        compare_frame("sat_frame", base, f);

        make_req(f, {16'h0200, $urandom()}, $urandom(), 16'($urandom()));
        base = rx_q.size();
        strobe(f);
        k = 0;
        while (rx_q.size() < base + 20 && k < 500) begin
            step();
            k++;
        end
        check("mid_reach", 32'(rx_q.size() >= base + 20), 32'd1);
        rst_n = 1'b0;
        step();
        check("mid_valid", 32'(mac_valid_o), 32'd0);
        check("mid_busy", 32'(busy_o), 32'd0);
        check("mid_drop", 32'(drop_cnt_o), 32'd0);
        rst_n = 1'b1;
        step();
        make_req(f, {16'h0200, $urandom()}, $urandom(), 16'($urandom()));
        run_frame("post_rst", f, base);
        check("final_vgap", 32'(vgap_err), 32'd0);
        check("final_hold", 32'(hold_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/icmp_reply_tx.md
Name: icmp_reply_tx

Overview:
- Downstream of the ICMP parser: takes one validated echo-request frame (ether_icmp_frame_t from icmp_pkg, byte 0 in the MSBs) and builds the echo reply.
- Reply changes: MAC and IP addresses swapped, ICMP type 8 set to 0, ICMP checksum updated.
- Streams the reply byte-serially to the Ethernet MAC transmit side, with a ready handshake and an enforced inter-frame gap.

Parameters:
- FRM_SZ, 74, frame length in bytes; must equal lp_ICMP_FRM_SZ.
- IFG_CYCLES, 12, idle cycles forced after each frame.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- hw_addr_i  in  48  local MAC, used as reply source MAC
- ip_addr_i  in  32  local IP, used as reply source IP
- icmp_pkt_i  in  FRM_SZ*8  parsed request frame (ether_icmp_frame_t)
- icmp_pkt_valid_i  in  1  one-cycle strobe, request frame valid
- mac_data_o  out  8  transmit byte
- mac_valid_o  out  1  mac_data_o valid
- mac_ready_i  in  1  MAC accepts current byte
- busy_o  out  1  high in any state other than ST_IDLE
- drop_cnt_o  out  8  requests dropped while busy, saturating

Behaviour:
- Reset:
  - Reset is synchronous, active-low; clk and rst_n are the only clock and reset.
  - While rst_n=0 at a clk edge: mac_data_o=0, mac_valid_o=0, busy_o=0, drop_cnt_o=0, state=ST_IDLE, frame buffer cleared.
  - Reset mid-frame: mac_valid_o drops at the next edge; no partial-frame recovery.
- Byte offsets in the frame:
  - Ethernet: dst MAC 0-5, src MAC 6-11.
  - IPv4: src IP 26-29, dst IP 30-33.
  - ICMP: type 34, code 35, checksum 36-37.
- ST_IDLE:
  - When icmp_pkt_valid_i=1, latch icmp_pkt_i into the reply buffer and go to ST_BUILD.
  - Otherwise stay in ST_IDLE.
- ST_BUILD (1 cycle):
  - dst MAC = request src MAC; src MAC = hw_addr_i.
  - dst IP = request src IP; src IP = ip_addr_i.
  - Byte 34 = 0x00.
  - ICMP checksum: new = old + 0x0800 (16-bit one's-complement add, end-around carry folded once).
  - IP header checksum is unchanged, because the address swap is sum-neutral.
  - Go to ST_SEND with byte index = 0.
- ST_SEND:
  - mac_valid_o=1; mac_data_o = buffer byte at the current index.
  - Index advances only on a cycle with mac_ready_i=1.
  - mac_valid_o stays high from the first byte to the last byte. If mac_ready_i=0, mac_data_o holds.
  - When byte FRM_SZ-1 is accepted, go to ST_GAP; mac_valid_o=0 in the following cycle.
- ST_GAP:
  - Counter runs IFG_CYCLES cycles with mac_valid_o=0, then the block returns to ST_IDLE.
- Latency:
  - Strobe sampled at edge N; first byte valid after edge N+2.
  - With mac_ready_i held high, the last byte is after edge N+FRM_SZ+1, and the block is back in ST_IDLE after edge N+FRM_SZ+2+IFG_CYCLES.
- Drops and width rules:
  - icmp_pkt_valid_i=1 in any non-IDLE state drops the request and increments drop_cnt_o by 1, saturating at 0xFF.
  - A request is accepted only when state is ST_IDLE at the sampling edge.
  - The byte index is $clog2(FRM_SZ) bits wide; the gap counter is $clog2(IFG_CYCLES+1) bits wide.
  - Checksum arithmetic uses a 17-bit sum, folded.

Optional Feature:
- ICMP_CSUM_RECALC_EN defined:
  - ST_BUILD is replaced by ST_CSUM, which computes a full ICMP checksum.
  - Checksum field 36-37 is treated as zero; one 16-bit word per cycle is summed over bytes 34..FRM_SZ-1.
  - A trailing odd byte is padded with 0x00 in its low byte. Carries are accumulated in a 32-bit sum, folded twice, then inverted.
  - Latency grows by ceil((FRM_SZ-34)/2) cycles; everything else is unchanged.
  - Result is correct even when the request checksum was wrong.
- Not defined: incremental update only, as in ST_BUILD.

Test Plan:
- Basic reply: request with src MAC 02:00:00:00:00:01, src IP 10.0.0.1, ICMP checksum 0x4D5A; hw_addr_i=02:00:00:00:00:AA, ip_addr_i=10.0.0.2; mac_ready_i=1.
  -> 74 contiguous bytes: dst MAC ..:01, src MAC ..:AA, IP 10.0.0.2 to 10.0.0.1, byte 34=0x00, checksum 0x555A; first byte 2 cycles after the strobe.
- Checksum wrap: request checksum 0xF800 -> reply 0x0001 (carry folded); request checksum 0xF7FF -> reply 0xFFFF.
- Backpressure: mac_ready_i low on every third cycle during ST_SEND.
  -> no byte skipped or duplicated; mac_valid_o never drops mid-frame; total 74 bytes.
- Drops: second strobe at 10 cycles after the first, third strobe during ST_GAP.
  -> drop_cnt_o=2, exactly one frame sent; a strobe sent after busy_o falls is accepted.
- Saturation: 300 strobes while busy -> drop_cnt_o=0xFF.
- Reset mid-frame: rst_n=0 at byte 20 -> next cycle mac_valid_o=0, busy_o=0, drop_cnt_o=0; a new request afterwards produces a complete, correct frame.
- With ICMP_CSUM_RECALC_EN defined: request carries a deliberately bad checksum 0x0000 -> reply carries the correct full recomputed checksum; first byte is delayed by 20 additional cycles (FRM_SZ=74).
